// File: rtl/cpi_global_fabric_if.sv
// CPI global channel bundle between the agent-side controller (master)
// and the fabric-side endpoint (slave).
interface cpi_global_fabric_if #(
    parameter int EPOCH_W = 8
);
    logic               txcon_req;
    logic               fatal;
    logic               viral;
    logic [EPOCH_W-1:0] epoch_id;
    logic [EPOCH_W-1:0] epoch_commit;
    logic [EPOCH_W-1:0] epoch_reject;
    logic               rx_push;
    logic               rx_pop;
    logic               rxcon_ack;
    logic               rxdiscon_nack;
    logic               rx_empty;
    logic               rx_full;
    logic               link_up;
    logic               viral_seen;
    logic               fatal_seen;
    logic [2:0]         err;
    logic [EPOCH_W-1:0] epoch_open;
    logic               epoch_rej_pulse;

    modport master (
        output txcon_req, fatal, viral, epoch_id, epoch_commit, epoch_reject, rx_push, rx_pop,
        input  rxcon_ack, rxdiscon_nack, rx_empty, rx_full, link_up, viral_seen, fatal_seen,
               err, epoch_open, epoch_rej_pulse
    );

    modport slave (
        input  txcon_req, fatal, viral, epoch_id, epoch_commit, epoch_reject, rx_push, rx_pop,
        output rxcon_ack, rxdiscon_nack, rx_empty, rx_full, link_up, viral_seen, fatal_seen,
               err, epoch_open, epoch_rej_pulse
    );
endinterface

// File: rtl/cpi_global_fabric.sv
// Fabric-side CPI global channel endpoint: connect/disconnect handshake,
// RX queue occupancy tracking and epoch-reject change detection.
module cpi_global_fabric #(
    parameter int EPOCH_W  = 8,
    parameter int RX_DEPTH = 16,
    parameter int ACK_DLY  = 4,
    parameter int DISC_DLY = 2
) (
    input  logic              clk,
    input  logic              rst,
    cpi_global_fabric_if.slave bus
);
    localparam int              CNT_W     = $clog2(RX_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RX_DEPTH);
    localparam logic [3:0]       ACK_LOAD  = 4'(ACK_DLY - 1);
    localparam logic [3:0]       DISC_LOAD = 4'(DISC_DLY - 1);

    typedef enum logic [2:0] {
        ST_DISCON    = 3'd0,
        ST_CONN_WAIT = 3'd1,
        ST_CONN      = 3'd2,
        ST_NACK      = 3'd3,
        ST_DISC_WAIT = 3'd4,
        ST_FATAL     = 3'd5
    } state_t;

    state_t             state_r, state_s;
    logic [3:0]         dly_r, dly_s;
    logic [CNT_W-1:0]   count_r, count_s;
    logic [2:0]         err_r, err_s;
    logic               push_ok_s;
    logic               ack_s, nack_s, link_s, fatal_s;
    logic               ack_r, nack_r, link_r, fatal_r, viral_r;
    logic               empty_r, full_r, pulse_r;
    logic [EPOCH_W-1:0] open_r, shadow_r;
    logic               unused_s;

    // State register and handshake delay counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_DISCON;
            dly_r   <= 4'd0;
        end else begin
            state_r <= state_s;
            dly_r   <= dly_s;
        end
    end

    // Next-state logic; fatal overrides every other transition.
    always_comb begin
        state_s = state_r;
        dly_s   = dly_r;
        if (bus.fatal) begin
            state_s = ST_FATAL;
            dly_s   = 4'd0;
        end else begin
            case (state_r)
                ST_DISCON: begin
                    if (bus.txcon_req) begin
                        state_s = ST_CONN_WAIT;
                        dly_s   = ACK_LOAD;
                    end else begin
                        state_s = ST_DISCON;
                    end
                end
                ST_CONN_WAIT: begin
                    if (!bus.txcon_req) begin
                        state_s = ST_DISCON;
                        dly_s   = 4'd0;
                    end else if (dly_r == 4'd0) begin
                        state_s = ST_CONN;
                    end else begin
                        dly_s = dly_r - 4'd1;
                    end
                end
                ST_CONN: begin
                    if (bus.txcon_req) begin
                        state_s = ST_CONN;
                    end else if (count_r == CNT_ZERO) begin
                        state_s = ST_DISC_WAIT;
                        dly_s   = DISC_LOAD;
                    end else begin
                        state_s = ST_NACK;
                    end
                end
                ST_NACK: begin
                    if (bus.txcon_req) begin
                        state_s = ST_CONN;
                    end else begin
                        state_s = ST_NACK;
                    end
                end
                ST_DISC_WAIT: begin
                    if (dly_r == 4'd0) begin
                        state_s = ST_DISCON;
                    end else begin
                        dly_s = dly_r - 4'd1;
                    end
                end
                ST_FATAL: state_s = ST_FATAL;
                default: begin
                    state_s = ST_DISCON;
                    dly_s   = 4'd0;
                end
            endcase
        end
    end

    // Output decode from the next state so the registered outputs track the state.
    always_comb begin
        ack_s   = 1'b0;
        nack_s  = 1'b0;
        link_s  = 1'b0;
        fatal_s = 1'b0;
        case (state_s)
            ST_CONN: begin
                ack_s  = 1'b1;
                link_s = 1'b1;
            end
            ST_NACK: begin
                ack_s  = 1'b1;
                nack_s = 1'b1;
                link_s = 1'b1;
            end
            ST_DISC_WAIT: ack_s   = 1'b1;
            ST_FATAL:     fatal_s = 1'b1;
            default:      ack_s   = 1'b0;
        endcase
    end

    // RX occupancy: a push only counts while linked; a dropped push never cancels a pop.
    always_comb begin
        count_s   = count_r;
        err_s     = err_r;
        push_ok_s = bus.rx_push && link_r;
        if (bus.rx_push && !link_r) begin
            err_s[2] = 1'b1;
        end else begin
            err_s[2] = err_r[2];
        end
        if (push_ok_s && bus.rx_pop) begin
            count_s = count_r;
        end else if (push_ok_s) begin
            if (count_r == CNT_FULL) begin
                err_s[0] = 1'b1;
            end else begin
                count_s = count_r + CNT_ONE;
            end
        end else if (bus.rx_pop) begin
            if (count_r == CNT_ZERO) begin
                err_s[1] = 1'b1;
            end else begin
                count_s = count_r - CNT_ONE;
            end
        end else begin
            count_s = count_r;
        end
    end

    // Registered handshake, status and occupancy outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_r   <= 1'b0;
            nack_r  <= 1'b0;
            link_r  <= 1'b0;
            fatal_r <= 1'b0;
            viral_r <= 1'b0;
            count_r <= CNT_ZERO;
            err_r   <= 3'b000;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
        end else begin
            ack_r   <= ack_s;
            nack_r  <= nack_s;
            link_r  <= link_s;
            fatal_r <= fatal_s;
            viral_r <= viral_r | bus.viral;
            count_r <= count_s;
            err_r   <= err_s;
            empty_r <= (count_s == CNT_ZERO);
            full_r  <= (count_s == CNT_FULL);
        end
    end

    // Epoch tracking: reject changes are only reported while the link is up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_r <= {EPOCH_W{1'b0}};
            pulse_r  <= 1'b0;
            open_r   <= {EPOCH_W{1'b0}};
        end else begin
            shadow_r <= bus.epoch_reject;
            pulse_r  <= link_r && (bus.epoch_reject != shadow_r);
            if (link_r) begin
                open_r <= bus.epoch_id;
            end else begin
                open_r <= open_r;
            end
        end
    end

    assign unused_s            = ^bus.epoch_commit;
    assign bus.rxcon_ack       = ack_r;
    assign bus.rxdiscon_nack   = nack_r;
    assign bus.rx_empty        = empty_r;
    assign bus.rx_full         = full_r;
    assign bus.link_up         = link_r;
    assign bus.viral_seen      = viral_r;
    assign bus.fatal_seen      = fatal_r;
    assign bus.err             = err_r;
    assign bus.epoch_open      = open_r;
    assign bus.epoch_rej_pulse = pulse_r;
endmodule
